exception_ctrl: RTL
===================

# exception_ctrl

Commit-stage exception arbiter for the dual-issue MIPS core. It collects per-slot exception bits and the pending hardware interrupt, and picks the single architecturally first exception. It drives the exception_flag/exception_type/exception_first_inst inputs of cp0_reg, flushes the pipeline, and hands fetch a redirect PC through a valid/ready handshake.

## Interface
Parameters:
- EXC_OFFSET, 32'h0000_0180: general exception vector offset added to EBase.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- slot1_valid_i / slot2_valid_i  in  1 each  commit-slot instruction valid; slot2 valid implies slot1 valid
- slot1_exc_i / slot2_exc_i  in  9 each  per-slot exception bits, one bit per cause: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Tr, [4] Sys, [5] Bp, [6] AdEL-data, [7] AdES, [8] ERET
- status_i, cause_i, epc_i, ebase_i  in  32 each  current CP0 register values
- cp0_we_i  in  1  MTC0 write strobe at commit
- cp0_waddr_i  in  5  MTC0 target register
- cp0_wsel_i  in  3  MTC0 target select
- cp0_wdata_i  in  32  MTC0 write data
- exception_flag_o  out  1  exception taken this cycle
- exception_type_o  out  5  ExcCode of the taken exception
- exception_first_inst_o  out  1  1 = slot1 took it, 0 = slot2
- flush_o  out  1  kill all younger pipeline state
- stall_o  out  1  hold commit while a redirect is outstanding
- redirect_valid_o  out  1  redirect PC offered to fetch
- redirect_pc_o  out  32  target PC
- redirect_ready_i  in  1  fetch accepts redirect

## Operation
- States:
  - IDLE: arbitration enabled.
  - REDIRECT: redirect_valid_o=1; arbitration disabled (exception_flag_o=0); stall_o=1.
- Interrupt request register: int_req_q <= status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]), updated every cycle.
- In IDLE the interrupt is taken on the oldest valid slot: slot1 if valid, else nothing (wait).
  - An interrupt always beats any slot exception in the same cycle.
- If no interrupt is taken, slot1 is checked before slot2. Slot2 is examined only when slot1 is valid with no exception bits set.
- Within one slot, priority runs from [0] (highest) up to [8]. Codes:
  - INT 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0a, Ov 0x0c, Tr 0x0d, ERET 0x0e.
- On a take in IDLE (cycle T), all of the following hold in T:
  - exception_flag_o=1, exception_type_o and exception_first_inst_o driven.
  - flush_o=1.
  - Next state is REDIRECT.
  - redirect_pc_q latched:
    - ERET: EPC.
    - Anything else: ebase_i + EXC_OFFSET, 32-bit add, wraps mod 2^32.
- EPC bypass for ERET: when cp0_we_i=1, cp0_waddr_i=14 and cp0_wsel_i=0 in the same cycle, cp0_wdata_i is used instead of epc_i. This covers an MTC0 EPC in slot1 followed by ERET in slot2.
- REDIRECT -> IDLE on the first cycle with redirect_ready_i=1.
- Invalid slots: exception bits are ignored.

## Timing
- Reset values:
  - All outputs are 0; redirect_pc_o is 32'h0.
  - State = IDLE; int_req_q = 0.
- Exception outputs and flush_o are combinational in cycle T, so cp0_reg samples them at the T edge.
- redirect_valid_o / redirect_pc_o are registered and valid from T+1. They hold steady until a ready handshake.
  - Minimum latency, take to redirect accepted: 1 cycle.
- int_req_q adds one cycle of interrupt latency.
  - After a take, EXL is set at the T edge. int_req_q can still read stale in T+1, but that cycle is always REDIRECT, so no spurious second take can occur.
- Simultaneous cases:
  - Interrupt plus exception in slot1: INT wins, first_inst=1.
  - Exceptions in both slots: slot1 wins.
- Reset asserted in REDIRECT: return to IDLE with redirect_valid_o=0 at the next edge, and no handshake is required.

## Structure
- ExcCode constants, the slot exception bit indices, EXC_OFFSET and the CP0 register numbers (EPC=14) are shared constants in defines.v.
- Natural sub-module: exc_prio_enc, a per-slot priority encoder from 9 bits to {hit, ExcCode}, instantiated twice.
- The FSM, interrupt register and redirect register stay in the top.

## Test plan
- Slot1 valid with RI, ebase_i=32'hBFC0_0200 -> in T: flag=1, type=0x0a, first_inst=1, flush=1. At T+1: redirect_valid=1, pc=32'hBFC0_0380.
- Slot1 clean, slot2 Ov -> type=0x0c, first_inst=0. With redirect_ready_i held low for 3 cycles, redirect stays valid, stall=1, and a new slot1 Sys in that window is ignored.
- status_i=32'h0000_0401 and cause_i[10]=1, with slot1 carrying Bp -> one cycle after int_req_q rises: type=0x00, first_inst=1, Bp suppressed. The following redirect cycle with stale int_req_q gives no second flag.
- MTC0 EPC with wdata=32'h8000_1234 and ERET in slot2, epc_i=0 -> type=0x0e, pc=32'h8000_1234.
- ebase_i=32'hFFFF_FF00 with Sys -> pc=32'h0000_0080 (wrap).
- rst asserted in REDIRECT -> next cycle redirect_valid=0, state IDLE, and an exception is taken normally afterwards.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the commit-stage exception arbiter: exception bit
// layout, MIPS ExcCodes, CP0 register numbers and the FSM state type.
package exception_ctrl_pkg;

    localparam int EXC_BITS = 9;

    // Bit positions within a slot's exception vector, highest priority first
    localparam int EXC_BIT_ADEL_IF = 0;
    localparam int EXC_BIT_RI      = 1;
    localparam int EXC_BIT_OV      = 2;
    localparam int EXC_BIT_TR      = 3;
    localparam int EXC_BIT_SYS     = 4;
    localparam int EXC_BIT_BP      = 5;
    localparam int EXC_BIT_ADEL_D  = 6;
    localparam int EXC_BIT_ADES    = 7;
    localparam int EXC_BIT_ERET    = 8;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;
    localparam logic [4:0] EXCCODE_TR   = 5'h0d;
    localparam logic [4:0] EXCCODE_ERET = 5'h0e;

    localparam logic [31:0] EXC_OFFSET_DEFAULT = 32'h0000_0180;

    localparam logic [4:0] CP0_REG_EPC = 5'd14;
    localparam logic [2:0] CP0_SEL_EPC = 3'd0;

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } exc_state_e;

    function automatic logic [4:0] exc_bit_code(input int idx);
        logic [4:0] code;
        case (idx)
            EXC_BIT_ADEL_IF: code = EXCCODE_ADEL;
            EXC_BIT_RI:      code = EXCCODE_RI;
            EXC_BIT_OV:      code = EXCCODE_OV;
            EXC_BIT_TR:      code = EXCCODE_TR;
            EXC_BIT_SYS:     code = EXCCODE_SYS;
            EXC_BIT_BP:      code = EXCCODE_BP;
            EXC_BIT_ADEL_D:  code = EXCCODE_ADEL;
            EXC_BIT_ADES:    code = EXCCODE_ADES;
            EXC_BIT_ERET:    code = EXCCODE_ERET;
            default:         code = EXCCODE_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Per-slot priority encoder: lowest set exception bit wins and is mapped to
// its ExcCode. An invalid slot never reports a hit.
module exc_prio_enc
    import exception_ctrl_pkg::*;
(
    input  logic                valid_i,
    input  logic [EXC_BITS-1:0] exc_i,
    output logic                hit_o,
    output logic [4:0]          code_o
);

    logic [4:0] code_tab [EXC_BITS];

    generate
        for (genvar gi = 0; gi < EXC_BITS; gi++) begin : g_code_tab
            assign code_tab[gi] = exc_bit_code(gi);
        end
    endgenerate

    // Scan from lowest priority upward so the highest-priority hit is kept last
    always_comb begin
        hit_o  = 1'b0;
        code_o = EXCCODE_INT;
        for (int i = EXC_BITS - 1; i >= 0; i--) begin
            if (valid_i && exc_i[i]) begin
                hit_o  = 1'b1;
                code_o = code_tab[i];
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception arbiter: picks the architecturally first exception
// across both commit slots and the pending interrupt, then offers fetch a redirect.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_OFFSET = EXC_OFFSET_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slot1_valid_i,
    input  logic          slot2_valid_i,
    input  logic [8:0]    slot1_exc_i,
    input  logic [8:0]    slot2_exc_i,
    input  logic [31:0]   status_i,
    input  logic [31:0]   cause_i,
    input  logic [31:0]   epc_i,
    input  logic [31:0]   ebase_i,
    input  logic          cp0_we_i,
    input  logic [4:0]    cp0_waddr_i,
    input  logic [2:0]    cp0_wsel_i,
    input  logic [31:0]   cp0_wdata_i,
    output logic          exception_flag_o,
    output logic [4:0]    exception_type_o,
    output logic          exception_first_inst_o,
    output logic          flush_o,
    output logic          stall_o,
    output logic          redirect_valid_o,
    output logic [31:0]   redirect_pc_o,
    input  logic          redirect_ready_i
);

    exc_state_e  state_reg, state_next;
    logic        int_req_reg;
    logic        int_req_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;

    logic        slot1_hit, slot2_hit;
    logic [4:0]  slot1_code, slot2_code;
    logic        take_int, take_slot1, take_slot2;
    logic [31:0] epc_src;
    logic        exc_flag;
    logic [4:0]  exc_type;
    logic        exc_first;

    logic        unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    exc_prio_enc u_enc_slot1 (
        .valid_i (slot1_valid_i),
        .exc_i   (slot1_exc_i),
        .hit_o   (slot1_hit),
        .code_o  (slot1_code)
    );

    exc_prio_enc u_enc_slot2 (
        .valid_i (slot2_valid_i),
        .exc_i   (slot2_exc_i),
        .hit_o   (slot2_hit),
        .code_o  (slot2_code)
    );

    assign int_req_next = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));

    // Interrupt attaches to the oldest valid slot; slot2 only counts behind a clean slot1
    assign take_int   = int_req_reg & slot1_valid_i;
    assign take_slot1 = slot1_hit;
    assign take_slot2 = slot1_valid_i & ~slot1_hit & slot2_hit;

    // MTC0 EPC committing alongside an ERET must be seen by that ERET
    assign epc_src = (cp0_we_i && cp0_waddr_i == CP0_REG_EPC && cp0_wsel_i == CP0_SEL_EPC)
                     ? cp0_wdata_i : epc_i;

    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        exc_flag         = 1'b0;
        exc_type         = EXCCODE_INT;
        exc_first        = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    if (take_int || take_slot1 || take_slot2) begin
                        exc_flag   = 1'b1;
                        state_next = ST_REDIRECT;
                        if (take_int) begin
                            exc_type  = EXCCODE_INT;
                            exc_first = 1'b1;
                        end else if (take_slot1) begin
                            exc_type  = slot1_code;
                            exc_first = 1'b1;
                        end else begin
                            exc_type  = slot2_code;
                            exc_first = 1'b0;
                        end
                        redirect_pc_next = (exc_type == EXCCODE_ERET) ? epc_src
                                                                      : ebase_i + EXC_OFFSET;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            int_req_reg     <= 1'b0;
            redirect_pc_reg <= 32'h0;
        end else begin
            state_reg       <= state_next;
            int_req_reg     <= int_req_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    assign exception_flag_o       = exc_flag;
    assign exception_type_o       = exc_type;
    assign exception_first_inst_o = exc_first;
    assign flush_o                = exc_flag;
    assign stall_o                = (state_reg == ST_REDIRECT);
    assign redirect_valid_o       = (state_reg == ST_REDIRECT);
    assign redirect_pc_o          = redirect_pc_reg;

endmodule
